// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - two-requester round-robin ALU issue arbiter with a one-entry result register
// Optional feature macro: ALU_ARB_ERR_EN (adds res_err for unlisted funct codes)
module alu_issue_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [5:0]       req0_funct,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [4:0]       req0_shamt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [5:0]       req1_funct,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req1_shamt,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready
`ifdef ALU_ARB_ERR_EN
    ,
    output logic             res_err
`endif
);

    localparam logic [5:0] FUNCT_ADD = 6'b100001;
    localparam logic [5:0] FUNCT_SUB = 6'b100011;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [5:0]       sel_funct;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [4:0]       sel_shamt;
    logic [WIDTH-1:0] alu_result;

    // A lone requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // The output slot is free when empty or when its current result drains this cycle.
    assign can_accept = rst_n && ((state == IDLE) || res_ready);
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        sel_funct = req0_funct;
        sel_a     = req0_a;
        sel_b     = req0_b;
        sel_shamt = req0_shamt;
        if (grant) begin
            sel_funct = req1_funct;
            sel_a     = req1_a;
            sel_b     = req1_b;
            sel_shamt = req1_shamt;
        end
    end

    always_comb begin
        alu_result = '0;
        case (sel_funct)
            FUNCT_ADD: alu_result = sel_a + sel_b;
            FUNCT_SUB: alu_result = sel_a - sel_b;
            FUNCT_SLL: alu_result = sel_b << sel_shamt;
            FUNCT_OR:  alu_result = sel_a | sel_b;
            default:   alu_result = '0;
        endcase
    end

`ifdef ALU_ARB_ERR_EN
    logic alu_illegal;

    always_comb begin
        alu_illegal = 1'b1;
        case (sel_funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_SLL, FUNCT_OR: alu_illegal = 1'b0;
            default:                                   alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_err <= 1'b0;
        end else if (accept) begin
            res_err <= alu_illegal;
        end else if ((state == HOLD) && res_ready) begin
            res_err <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            state      <= HOLD;
            res_valid  <= 1'b1;
            res_data   <= alu_result;
            res_id     <= grant;
            last_grant <= grant;
        end else if ((state == HOLD) && res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - scoreboard bench for alu_issue_arbiter
module tb_alu_issue_arbiter;

    localparam int W = 32;
    localparam logic [5:0] F_ADD = 6'b100001;
    localparam logic [5:0] F_SUB = 6'b100011;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_BAD = 6'b101010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [5:0]   req0_funct, req1_funct;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]   req0_shamt, req1_shamt;
    logic         req0_ready, req1_ready;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_id;
    logic         res_ready;
`ifdef ALU_ARB_ERR_EN
    logic         res_err;
`endif

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   num_checks = 0;
    int   num_errors = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_funct(req0_funct), .req0_a(req0_a),
        .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_funct(req1_funct), .req1_a(req1_a),
        .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready)
`ifdef ALU_ARB_ERR_EN
        , .res_err(res_err)
`endif
    );

    function automatic logic [W-1:0] model_data(input logic [5:0] f, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [4:0] sh);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_SLL:   return b << sh;
            F_OR:    return a | b;
            default: return '0;
        endcase
    endfunction

    function automatic logic model_err(input logic [5:0] f);
        return !(f == F_ADD || f == F_SUB || f == F_SLL || f == F_OR);
    endfunction

    task automatic push_exp(input logic id, input logic [5:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [4:0] sh);
        exp_t e;
        e.id   = id;
        e.data = model_data(f, a, b, sh);
        e.err  = model_err(f);
        sb.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [5:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] sh);
        if (id) begin
            req1_valid = v; req1_funct = f; req1_a = a; req1_b = b; req1_shamt = sh;
        end else begin
            req0_valid = v; req0_funct = f; req0_a = a; req0_b = b; req0_shamt = sh;
        end
    endtask

    // Presents one op until its ready is seen (bounded); queues the expected result on acceptance.
    task automatic issue(input logic id, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input bit push, output bit ok);
        ok = 1'b0;
        set_req(id, 1'b1, f, a, b, sh);
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                if (push) push_exp(id, f, a, b, sh);
            end
            @(posedge clk); #1;
        end
        set_req(id, 1'b0, F_ADD, '0, '0, '0);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            num_checks++;
            if (sb.size() == 0) begin
                num_errors++;
                $display("FAIL result_unexpected: got id=%0d data=%h, required no result", res_id, res_data);
            end else begin
                e = sb.pop_front();
`ifdef ALU_ARB_ERR_EN
                if (res_id !== e.id || res_data !== e.data || res_err !== e.err) begin
                    num_errors++;
                    $display("FAIL result: got id=%0d data=%h err=%0b, required id=%0d data=%h err=%0b",
                             res_id, res_data, res_err, e.id, e.data, e.err);
                end
`else
                if (res_id !== e.id || res_data !== e.data) begin
                    num_errors++;
                    $display("FAIL result: got id=%0d data=%h, required id=%0d data=%h",
                             res_id, res_data, e.id, e.data);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        res_ready = 1'b1;
        set_req(0, 1'b1, F_ADD, 32'd1, 32'd2, 5'd0);
        set_req(1, 1'b1, F_ADD, 32'd3, 32'd4, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        num_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            num_errors++;
            $display("FAIL reset_ready: got %0b%0b, required 00", req0_ready, req1_ready);
        end
        num_checks++;
        if (res_valid !== 1'b0 || res_data !== '0 || res_id !== 1'b0) begin
            num_errors++;
            $display("FAIL reset_outputs: got v=%0b d=%h id=%0b, required 0 0 0", res_valid, res_data, res_id);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        set_req(1, 1'b0, F_ADD, '0, '0, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int n0 = 0;
        int n1 = 0;
        logic g;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = logic'(k % 2);
            set_req(0, 1'b1, F_ADD, 32'h100 + n0, 32'd1, 5'd0);
            set_req(1, 1'b1, F_OR, 32'h200 + n1, 32'h1000, 5'd0);
            if (g) push_exp(1, F_OR, 32'h200 + n1, 32'h1000, 5'd0);
            else   push_exp(0, F_ADD, 32'h100 + n0, 32'd1, 5'd0);
            @(negedge clk);
            num_checks++;
            if (req0_ready !== !g || req1_ready !== g) begin
                num_errors++;
                $display("FAIL contention_grant%0d: got ready=%0b%0b, required grant %0d", k, req1_ready, req0_ready, g);
            end
            if (k > 0) begin
                num_checks++;
                if (res_valid !== 1'b1) begin
                    num_errors++;
                    $display("FAIL contention_b2b%0d: got res_valid=%0b, required 1", k, res_valid);
                end
            end
            @(posedge clk); #1;
            if (g) n1++;
            else   n0++;
        end
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        set_req(1, 1'b0, F_ADD, '0, '0, '0);
        drain();
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        set_req(0, 1'b1, F_ADD, 32'd5, 32'd7, 5'd0);
        push_exp(0, F_ADD, 32'd5, 32'd7, 5'd0);
        @(negedge clk);
        num_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            num_errors++;
            $display("FAIL single_ready: got %0b%0b, required r0=1 r1=0", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        @(negedge clk);
        num_checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd12 || res_id !== 1'b0) begin
            num_errors++;
            $display("FAIL single_result: got v=%0b d=%0d id=%0b, required 1 12 0", res_valid, res_data, res_id);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit ok;
        res_ready = 1'b0;
        issue(1, F_SUB, 32'd3, 32'd5, 5'd0, 1'b1, ok);
        num_checks++;
        if (!ok) begin
            num_errors++;
            $display("FAIL bp_accept: got no accept, required accept of req1");
        end
        set_req(0, 1'b1, F_ADD, 32'd1, 32'd2, 5'd0);
        set_req(1, 1'b1, F_SUB, 32'd10, 32'd4, 5'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            num_checks++;
            if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFE || res_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                num_errors++;
                $display("FAIL bp_stall%0d: got v=%0b d=%h id=%0b rdy=%0b%0b, required 1 fffffffe 1 00",
                         c, res_valid, res_data, res_id, req1_ready, req0_ready);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        push_exp(0, F_ADD, 32'd1, 32'd2, 5'd0);
        @(negedge clk);
        num_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            num_errors++;
            $display("FAIL bp_release: got rdy=%0b%0b, required r0=1 r1=0", req1_ready, req0_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        push_exp(1, F_SUB, 32'd10, 32'd4, 5'd0);
        @(negedge clk);
        num_checks++;
        if (req1_ready !== 1'b1) begin
            num_errors++;
            $display("FAIL bp_sole: got r1=%0b, required 1", req1_ready);
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, F_ADD, '0, '0, '0);
        drain();
    endtask

    task automatic test_shift_or();
        bit ok;
        res_ready = 1'b1;
        issue(0, F_SLL, 32'd0, 32'd1, 5'd31, 1'b1, ok);
        @(negedge clk);
        num_checks++;
        if (!ok || res_data !== 32'h8000_0000) begin
            num_errors++;
            $display("FAIL shift: got ok=%0b d=%h, required 1 80000000", ok, res_data);
        end
        @(posedge clk); #1;
        issue(0, F_OR, 32'hF0, 32'h0F, 5'd0, 1'b1, ok);
        @(negedge clk);
        num_checks++;
        if (!ok || res_data !== 32'hFF) begin
            num_errors++;
            $display("FAIL or: got ok=%0b d=%h, required 1 000000ff", ok, res_data);
        end
        drain();
    endtask

    task automatic test_reset_mid_hold();
        bit ok;
        res_ready = 1'b0;
        issue(0, F_ADD, 32'd9, 32'd9, 5'd0, 1'b0, ok);
        @(negedge clk);
        num_checks++;
        if (!ok || res_valid !== 1'b1) begin
            num_errors++;
            $display("FAIL midrst_hold: got ok=%0b v=%0b, required 1 1", ok, res_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_req(0, 1'b1, F_ADD, 32'd20, 32'd1, 5'd0);
        set_req(1, 1'b1, F_ADD, 32'd30, 32'd1, 5'd0);
        @(negedge clk);
        num_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            num_errors++;
            $display("FAIL midrst_ready: got %0b%0b, required 00", req1_ready, req0_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        push_exp(0, F_ADD, 32'd20, 32'd1, 5'd0);
        @(negedge clk);
        num_checks++;
        if (res_valid !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            num_errors++;
            $display("FAIL midrst_after: got v=%0b rdy=%0b%0b, required v=0 r0=1 r1=0", res_valid, req1_ready, req0_ready);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        set_req(1, 1'b0, F_ADD, '0, '0, '0);
        drain();
    endtask

    task automatic test_illegal();
        bit ok;
        res_ready = 1'b1;
        issue(1, F_BAD, 32'h1234, 32'h5678, 5'd3, 1'b1, ok);
        @(negedge clk);
        num_checks++;
`ifdef ALU_ARB_ERR_EN
        if (!ok || res_valid !== 1'b1 || res_data !== '0 || res_err !== 1'b1) begin
            num_errors++;
            $display("FAIL illegal: got ok=%0b v=%0b d=%h err=%0b, required 1 1 0 1", ok, res_valid, res_data, res_err);
        end
`else
        if (!ok || res_valid !== 1'b1 || res_data !== '0) begin
            num_errors++;
            $display("FAIL illegal: got ok=%0b v=%0b d=%h, required 1 1 0", ok, res_valid, res_data);
        end
`endif
        @(posedge clk); #1;
        issue(0, F_ADD, 32'd40, 32'd2, 5'd0, 1'b1, ok);
        num_checks++;
        if (!ok) begin
            num_errors++;
            $display("FAIL illegal_followup: got no accept, required accept");
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        res_ready = 1'b0;
        set_req(0, 1'b0, F_ADD, '0, '0, '0);
        set_req(1, 1'b0, F_ADD, '0, '0, '0);
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_shift_or();
        test_reset_mid_hold();
        test_illegal();
        num_checks++;
        if (sb.size() != 0) begin
            num_errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result bit width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports, for i in {0,1}: req<i>_valid  input  1  requester i presents an operation.
REQ-005 SHALL have ports: req<i>_funct  input  6  R-type funct code.
REQ-006 SHALL have ports: req<i>_a  input  WIDTH  first operand.
REQ-007 SHALL have ports: req<i>_b  input  WIDTH  second operand.
REQ-008 SHALL have ports: req<i>_shamt  input  5  shift amount.
REQ-009 SHALL have ports: req<i>_ready  output  1  operation accepted this cycle.
REQ-010 SHALL have port: res_valid  output  1  result held.
REQ-011 SHALL have port: res_data  output  WIDTH  result.
REQ-012 SHALL have port: res_id  output  1  index of the requester that owns the result.
REQ-013 SHALL have port: res_ready  input  1  consumer takes the result.

Function
REQ-014 SHALL implement states IDLE (no result held) and HOLD (result held, res_valid=1).
REQ-015 SHALL accept a request when req<i>_valid=1 and req<i>_ready=1; ready is combinational: 1 only for the granted requester, while in IDLE or in HOLD with res_ready=1.
REQ-016 SHALL grant, when both are valid, the requester not granted last (round-robin); the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-017 SHALL grant the sole valid requester regardless of the pointer; the pointer updates only on acceptance.
REQ-018 SHALL compute in the accept cycle and register the result: res_valid=1 the next cycle (latency 1).
REQ-019 SHALL decode funct as: 100001 a+b; 100011 a-b; 000000 b<<shamt; 100101 a|b.
REQ-020 SHALL perform add and subtract modulo 2^WIDTH, ignoring carry and overflow; the shift fills zeros.
REQ-021 SHALL move HOLD->IDLE on res_ready=1 with no acceptance, and stay in HOLD on res_ready=1 with a new acceptance (back-to-back, one result per cycle).
REQ-022 SHALL keep res_data and res_id stable while res_valid=1 and res_ready=0.
REQ-023 SHALL ignore req_* inputs when no grant is given; no request is dropped or duplicated.

Reset
REQ-024 SHALL, with rst_n=0 at a clock edge, set state IDLE, res_valid=0, res_data=0, res_id=0 and last-grant pointer=1.
REQ-025 SHALL force both req<i>_ready=0 while rst_n=0.
REQ-026 SHALL discard any held result on a mid-operation reset.

Configuration
REQ-027 SHALL, with ALU_ARB_ERR_EN defined, add port res_err  output  1; an unlisted funct is still accepted, and yields res_data=0 and res_err=1 with the result.
REQ-028 SHALL hold res_err stable under stall, clear it with the result, and reset it to 0.
REQ-029 SHALL, without ALU_ARB_ERR_EN, omit res_err; an unlisted funct is still accepted and yields res_data=0.

Verification
REQ-030 SHALL test single request: req0 funct=100001, a=5, b=7 -> next cycle res_valid=1, res_data=12, res_id=0.
REQ-031 SHALL test contention: both valid over 4 consecutive cycles with res_ready=1 -> grants 0,1,0,1 and four results in order.
REQ-032 SHALL test backpressure: res_ready=0 for 3 cycles after req1 funct=100011, a=3, b=5 -> res_data=0xFFFFFFFE held and both ready=0; release -> accepted.
REQ-033 SHALL test shift and or: funct=000000, b=1, shamt=31 -> 0x80000000; funct=100101, a=0xF0, b=0x0F -> 0xFF.
REQ-034 SHALL test reset mid-HOLD: rst_n=0 one cycle -> res_valid=0, next tie granted to requester 0.
REQ-035 SHALL test funct=101010 with ALU_ARB_ERR_EN -> res_err=1, res_data=0; without the macro -> res_data=0 and no hang.
